uart_rx: RTL and testbench

UART receiver for the serial link, consuming the 16x oversampling `tick` from the baud rate generator. It synchronizes the asynchronous `rx` line, qualifies start bits at mid-bit, and shifts in DATA_BITS data bits LSB first. It checks the stop bit and presents each received byte with a one-cycle `valid` pulse to the downstream command/processor logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud-table constants
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int CLK_HZ_DEFAULT     = 50_000_000;

  // Rounded clk divider producing one tick per 1/oversample of a bit.
  function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

  localparam int DIV_9600   = baud_div(CLK_HZ_DEFAULT, 9600,   OVERSAMPLE_DEFAULT);
  localparam int DIV_57600  = baud_div(CLK_HZ_DEFAULT, 57600,  OVERSAMPLE_DEFAULT);
  localparam int DIV_115200 = baud_div(CLK_HZ_DEFAULT, 115200, OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer for asynchronous inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with mid-bit sampling and framing check
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [CW-1:0]        os_cnt, os_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            os_n    = '0;
            state_n = START;
          end
        end
        START: begin
          if (os_cnt == OS_MID) begin
            os_n    = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            os_n  = '0;
            sh_n  = {rx_s, shreg[DATA_BITS-1:1]};
            bit_n = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state_n = STOP;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            state_n = rx_s ? IDLE : BREAK;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off re-arming until the line returns high.
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_n = tick && (state == STOP) && (os_cnt == OS_LAST);
    ferr_n  = valid_n && !rx_s;
    data_n  = valid_n ? shreg : data;
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8-bit and 7-bit instances)
module tb_uart_rx;

  logic       clk;
  logic       arst_n;
  logic       tick;
  logic       rx;
  logic [7:0] data8;
  logic       valid8, ferr8, busy8;
  logic [6:0] data7;
  logic       valid7, ferr7, busy7;

  int n_tests = 0;
  int n_fail  = 0;

  logic tick_en = 1'b1;
  int   tdiv    = 0;
  int   tick_cnt   = 0;
  int   start_mark = 0;
  int   vcnt  = 0;
  logic [7:0] vdata = '0;
  logic vferr = 1'b0;
  logic vbusy = 1'b1;
  int   vticks[$];
  int   vcnt7 = 0;
  logic [6:0] vdata7 = '0;
  logic vferr7 = 1'b0;
  logic valid_prev = 1'b0;
  int   wide_pulses = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx),
    .data(data8), .valid(valid8), .frame_err(ferr8), .busy(busy8)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx),
    .data(data7), .valid(valid7), .frame_err(ferr7), .busy(busy7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clk, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      tick = tick_en && (tdiv == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (tick) tick_cnt++;
    if (valid8) begin
      vcnt++;
      vdata = data8;
      vferr = ferr8;
      vbusy = busy8;
      vticks.push_back(tick_cnt);
      if (valid_prev) wide_pulses++;
    end
    valid_prev = valid8;
    if (valid7) begin
      vcnt7++;
      vdata7 = data7;
      vferr7 = ferr7;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      @(posedge clk);
      while (!tick && g < 50) begin
        @(posedge clk);
        g++;
      end
      if (g >= 50) begin
        n_tests++;
        n_fail++;
        $error("FAIL tick_wait: observed no tick expected tick within 50 clk");
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    wait_ticks(16);
  endtask

  task automatic send_start();
    #1 rx = 1'b0;
    #1 start_mark = tick_cnt;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_start();
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  initial begin
    int c0, q0;
    logic [7:0] b;
    arst_n = 1'b0;
    rx     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  {24'd0, data8}, 32'h00);
    check("rst_valid", {31'd0, valid8}, 32'd0);
    check("rst_ferr",  {31'd0, ferr8}, 32'd0);
    check("rst_busy",  {31'd0, busy8}, 32'd0);
    check("rst_busy7", {31'd0, busy7}, 32'd0);
    #2 arst_n = 1'b1;
    wait_ticks(10);

    // 0x55 with good stop bit; valid on tick 152 after detection
    c0 = vcnt;
    send_frame(8'h55, 1'b1);
    check("f55_count", vcnt - c0, 1);
    check("f55_data",  {24'd0, vdata}, 32'h55);
    check("f55_ferr",  {31'd0, vferr}, 32'd0);
    check("f55_busy_at_valid", {31'd0, vbusy}, 32'd0);
    check("f55_tick", vticks[vticks.size()-1] - start_mark - 1, 152);
    wait_ticks(8);

    // false start: low 4 ticks, rejected at tick 8
    c0 = vcnt;
    send_start_short: begin
      #1 rx = 1'b0;
      wait_ticks(4);
      #1 rx = 1'b1;
    end
    check("fs_busy_t3", {31'd0, busy8}, 32'd1);
    wait_ticks(4);
    #1 check("fs_busy_t7", {31'd0, busy8}, 32'd1);
    wait_ticks(1);
    #1 check("fs_busy_t8", {31'd0, busy8}, 32'd0);
    wait_ticks(8);
    check("fs_novalid", vcnt - c0, 0);
    send_frame(8'hC3, 1'b1);
    check("fC3_data", {24'd0, vdata}, 32'hC3);
    check("fC3_ferr", {31'd0, vferr}, 32'd0);
    check("fC3_count", vcnt - c0, 1);
    wait_ticks(8);

    // 0xA3 with stop=0 then line held low (break)
    c0 = vcnt;
    send_frame(8'hA3, 1'b0);
    wait_ticks(48);
    #1 check("brk_busy", {31'd0, busy8}, 32'd1);
    rx = 1'b1;
    wait_ticks(20);
    #1;
    check("brk_count", vcnt - c0, 1);
    check("brk_data",  {24'd0, vdata}, 32'hA3);
    check("brk_ferr",  {31'd0, vferr}, 32'd1);
    check("brk_idle",  {31'd0, busy8}, 32'd0);
    send_frame(8'h0F, 1'b1);
    check("f0F_data", {24'd0, vdata}, 32'h0F);
    check("f0F_ferr", {31'd0, vferr}, 32'd0);
    check("f0F_count", vcnt - c0, 2);
    wait_ticks(8);

    // back-to-back frames with no gap
    c0 = vcnt;
    q0 = vticks.size();
    send_frame(8'h00, 1'b1);
    check("b2b_d0", {24'd0, vdata}, 32'h00);
    send_frame(8'hFF, 1'b1);
    check("b2b_d1", {24'd0, vdata}, 32'hFF);
    send_frame(8'h81, 1'b1);
    check("b2b_d2", {24'd0, vdata}, 32'h81);
    check("b2b_count", vcnt - c0, 3);
    check("b2b_gap0", vticks[q0+1] - vticks[q0], 160);
    check("b2b_gap1", vticks[q0+2] - vticks[q0+1], 160);
    wait_ticks(8);

    // async reset after 3 data bits of 0x7E
    c0 = vcnt;
    b = 8'h7E;
    send_start();
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    #3 check("rst_mid_busy_before", {31'd0, busy8}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("rst_mid_data",  {24'd0, data8}, 32'h00);
    check("rst_mid_valid", {31'd0, valid8}, 32'd0);
    check("rst_mid_ferr",  {31'd0, ferr8}, 32'd0);
    check("rst_mid_busy",  {31'd0, busy8}, 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;
    wait_ticks(20);
    send_frame(8'h3C, 1'b1);
    check("f3C_data", {24'd0, vdata}, 32'h3C);
    check("f3C_count", vcnt - c0, 1);
    wait_ticks(40);

    // tick stalled 1000 clk mid-frame
    c0 = vcnt;
    q0 = vcnt7;
    b = 8'h96;
    send_start();
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    tick_en = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("stall_novalid", vcnt - c0, 0);
    check("stall_busy", {31'd0, busy8}, 32'd1);
    tick_en = 1'b1;
    for (int i = 4; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    check("f96_count", vcnt - c0, 1);
    check("f96_data",  {24'd0, vdata}, 32'h96);
    check("f96_ferr",  {31'd0, vferr}, 32'd0);
    check("f96_7b_count", vcnt7 - q0, 1);
    check("f96_7b_data",  {25'd0, vdata7}, 32'h16);
    check("f96_7b_ferr",  {31'd0, vferr7}, 32'd0);
    wait_ticks(8);
    check("valid_width", wide_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
